// File: rtl/aes_dec_iter.sv
// ---------------------------------------------------------------------------
// aes_dec_iter -- iterative AES-128 decryption engine
//
// Walks a ciphertext block through the inverse cipher one step per clock:
// INIT (initial AddRoundKey), then per round SHIFT (InvShiftRows), SUB_A/SUB_B
// (registered InvSubBytes), ARK (AddRoundKey) and, except in the last round,
// MIX (InvMixColumns, MIX_COLS columns per cycle).
// DONE after L = 5 + 9*(4 + 4/MIX_COLS) edges from the accept edge.
//
// Optional build macro AES_CBC_EN: adds AES_IV / AES_IV_LOAD and a 128-bit
// chain register so the output becomes CBC plaintext instead of ECB.
//
// Parameters
//   MIX_COLS       InvMixColumns instances / columns per MIX cycle (1, 2, 4)
// Ports
//   CLK            clock, rising edge
//   RESET_N        asynchronous active-low reset
//   AES_START      level request, accepted in IDLE when AES_KEY_VALID is high
//   AES_KEY_VALID  key schedule complete (checked only at accept)
//   AES_KEY_SCHED  11 round keys; slice k = round key 10-k
//   AES_MSG_ENC    ciphertext, sampled on the accept edge
//   AES_IV         CBC initial vector            (AES_CBC_EN only)
//   AES_IV_LOAD    load chain register in IDLE   (AES_CBC_EN only)
//   AES_BUSY       high in every state except IDLE and DONE
//   AES_DONE       result valid, held until AES_START falls
//   AES_MSG_DEC    registered plaintext
// ---------------------------------------------------------------------------
module aes_dec_iter #(
    parameter int MIX_COLS = 4
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          AES_START,
    input  logic          AES_KEY_VALID,
    input  logic [1407:0] AES_KEY_SCHED,
    input  logic [127:0]  AES_MSG_ENC,
`ifdef AES_CBC_EN
    input  logic [127:0]  AES_IV,
    input  logic          AES_IV_LOAD,
`endif
    output logic          AES_BUSY,
    output logic          AES_DONE,
    output logic [127:0]  AES_MSG_DEC
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_SUB_A = 3'd3;
    localparam logic [2:0] S_SUB_B = 3'd4;
    localparam logic [2:0] S_ARK   = 3'd5;
    localparam logic [2:0] S_MIX   = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    // Column groups per round; the counter is kept 1 bit wide (and pinned
    // to 0) when all four columns are mixed in one cycle.
    localparam int NGRP  = 4 / MIX_COLS;
    localparam int COL_W = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NGRP - 1);

    generate
        if (MIX_COLS != 1 && MIX_COLS != 2 && MIX_COLS != 4) begin : g_bad_mix_cols
            $error("aes_dec_iter: MIX_COLS must be 1, 2 or 4");
        end
    endgenerate

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a12  = gf_mul(a6, a6);
        a15  = gf_mul(a12, a3);
        a30  = gf_mul(a15, a15);
        a60  = gf_mul(a30, a30);
        a120 = gf_mul(a60, a60);
        a240 = gf_mul(a120, a120);
        a252 = gf_mul(a240, a12);
        return gf_mul(a252, a2);
    endfunction

    // Inverse S-box: undo the affine map, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int b = 0; b < 16; b++) o[8*b +: 8] = inv_sbox(s[8*b +: 8]);
        return o;
    endfunction

    // Byte (row r, column c) lives at bits [127-8*(r+4c) -: 8]; row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    logic [2:0]       state_q, state_d;
    logic [3:0]       round_q, round_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [127:0]     ct_q, ct_d;
    logic [127:0]     blk_q, blk_d;
    logic [127:0]     dec_q, dec_d;
    logic [127:0]     sub_q;
`ifdef AES_CBC_EN
    logic [127:0]     chain_q, chain_d;
`endif

    logic [127:0] key_slice [11];
    logic [127:0] round_key;
    logic [127:0] blk_ark;
    logic [31:0]  mix_out [MIX_COLS];
    logic [127:0] blk_mixed;

    always_comb begin
        for (int k = 0; k < 11; k++) key_slice[k] = AES_KEY_SCHED[128*k +: 128];
    end

    always_comb begin
        round_key = key_slice[0];
        if (round_q <= 4'd10) round_key = key_slice[round_q];
    end

    assign blk_ark = blk_q ^ round_key;

    // MIX_COLS InvMixColumns units are steered onto column group col_q.
    always_comb begin
        blk_mixed = blk_q;
        for (int j = 0; j < MIX_COLS; j++)
            mix_out[j] = inv_mix_col(blk_q[127 - 32*(int'(col_q)*MIX_COLS + j) -: 32]);
        for (int c = 0; c < 4; c++)
            if (c / MIX_COLS == int'(col_q)) blk_mixed[127 - 32*c -: 32] = mix_out[c % MIX_COLS];
    end

    always_comb begin
        // NOTE: every output gets a hold default first so no path infers a latch.
        state_d = state_q;
        round_d = round_q;
        col_d   = col_q;
        ct_d    = ct_q;
        blk_d   = blk_q;
        dec_d   = dec_q;
`ifdef AES_CBC_EN
        chain_d = chain_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef AES_CBC_EN
                if (AES_IV_LOAD) chain_d = AES_IV;
`endif
                if (AES_START && AES_KEY_VALID) begin
                    ct_d    = AES_MSG_ENC;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                blk_d   = ct_q ^ key_slice[0];
                round_d = 4'd1;
                col_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                blk_d   = inv_shift_rows(blk_q);
                state_d = S_SUB_A;
            end
            S_SUB_A: state_d = S_SUB_B;
            S_SUB_B: begin
                blk_d   = sub_q;
                state_d = S_ARK;
            end
            S_ARK: begin
                blk_d = blk_ark;
                if (round_q == 4'd10) begin
`ifdef AES_CBC_EN
                    dec_d   = blk_ark ^ chain_q;
                    chain_d = ct_q;
`else
                    dec_d   = blk_ark;
`endif
                    state_d = S_DONE;
                end else begin
                    state_d = S_MIX;
                end
            end
            S_MIX: begin
                blk_d = blk_mixed;
                if (col_q == COL_LAST) begin
                    col_d   = '0;
                    round_d = round_q + 4'd1;
                    state_d = S_SHIFT;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            S_DONE: if (!AES_START) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            round_q <= '0;
            col_q   <= '0;
            ct_q    <= '0;
            blk_q   <= '0;
            dec_q   <= '0;
`ifdef AES_CBC_EN
            chain_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            col_q   <= col_d;
            ct_q    <= ct_d;
            blk_q   <= blk_d;
            dec_q   <= dec_d;
`ifdef AES_CBC_EN
            chain_q <= chain_d;
`endif
        end
    end

    // NOTE: the S-box pipeline register carries no reset; it is always written in SUB_A before SUB_B reads it.
    always_ff @(posedge CLK) begin
        if (state_q == S_SUB_A) sub_q <= inv_sub_bytes(blk_q);
    end

    assign AES_BUSY    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign AES_DONE    = (state_q == S_DONE);
    assign AES_MSG_DEC = dec_q;

endmodule

// File: tb/tb_aes_dec_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_dec_iter -- self-checking bench for aes_dec_iter
//
// Three instances (MIX_COLS = 4, 2, 1) share every input. Expected plaintext
// comes from known FIPS-197 / SP800-38A vectors and from a byte-level AES-128
// encryption model (own S-box generation, key expansion, forward rounds):
// random plaintexts are encrypted here and must decrypt back in the DUTs.
// ---------------------------------------------------------------------------
module tb_aes_dec_iter;

    localparam int MC [3] = '{4, 2, 1};

    localparam logic [127:0] K_C1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K_CBC  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV_CBC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_B1  = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] PT_B1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT_B2  = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] PT_B2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          key_valid;
    logic [1407:0] key_sched;
    logic [127:0]  msg_enc;
`ifdef AES_CBC_EN
    logic [127:0]  iv;
    logic          iv_load;
`endif
    logic          busy [3];
    logic          done [3];
    logic [127:0]  dec  [3];

    int            n_vec;
    int            n_err;
    logic [127:0]  model_chain;
    logic [7:0]    sbox [256];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_dec_iter #(.MIX_COLS(g == 0 ? 4 : (g == 1 ? 2 : 1))) u_dut (
            .CLK           (clk),
            .RESET_N       (rst_n),
            .AES_START     (start),
            .AES_KEY_VALID (key_valid),
            .AES_KEY_SCHED (key_sched),
            .AES_MSG_ENC   (msg_enc),
`ifdef AES_CBC_EN
            .AES_IV        (iv),
            .AES_IV_LOAD   (iv_load),
`endif
            .AES_BUSY      (busy[g]),
            .AES_DONE      (done[g]),
            .AES_MSG_DEC   (dec[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "tb_aes_dec_iter watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic int lat_of(input int mc);
        return 5 + 9 * (4 + 4 / mc);
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [1407:0] expand_key(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] s;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            s[128*(10 - r) +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return s;
    endfunction

    function automatic logic [127:0] encrypt(input logic [1407:0] sched, input logic [127:0] pt);
        logic [7:0]   st [16];
        logic [7:0]   t  [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] rk;
        logic [127:0] o;
        for (int b = 0; b < 16; b++) st[b] = pt[127 - 8*b -: 8];
        for (int rnd = 0; rnd <= 10; rnd++) begin
            if (rnd > 0) begin
                for (int b = 0; b < 16; b++) st[b] = sbox[st[b]];
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) t[r + 4*c] = st[r + 4*((c + r) % 4)];
                st = t;
                if (rnd < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                        st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                        st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                        st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                        st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                    end
                end
            end
            rk = sched[128*(10 - rnd) +: 128];
            for (int b = 0; b < 16; b++) st[b] = st[b] ^ rk[127 - 8*b -: 8];
        end
        for (int b = 0; b < 16; b++) o[127 - 8*b -: 8] = st[b];
        return o;
    endfunction

    // ---------------- one operation on all three instances ----------------
    // drop_at < 0: START held until after every DONE; else START falls at that cycle.
    task automatic run_op(input logic [127:0] key, input logic [127:0] ct,
                          input logic [127:0] want, input int drop_at, input string name);
        int first [3];
        int hi    [3];
        int hold_end;
        int width;
        hold_end  = lat_of(1) + 3;
        key_sched = expand_key(key);
        msg_enc   = ct;
        key_valid = 1'b1;
        start     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            first[i] = -1;
            hi[i]    = 0;
        end
        for (int e = 0; e <= lat_of(1) + 5; e++) begin
            @(negedge clk);
            if (e == 0)
                check($sformatf("%s_busy_rise", name), {busy[0], busy[1], busy[2]}, 3'b111);
            for (int i = 0; i < 3; i++) begin
                if (done[i]) begin
                    hi[i]++;
                    if (first[i] < 0) begin
                        first[i] = e;
                        check($sformatf("%s_dec_mc%0d", name, MC[i]), dec[i], want);
                        check($sformatf("%s_busy_fall_mc%0d", name, MC[i]), busy[i], 1'b0);
                    end
                end
            end
            if (start && ((drop_at >= 0 && e == drop_at) || (drop_at < 0 && e == hold_end)))
                start = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            width = (drop_at >= 0) ? 1 : hold_end - lat_of(MC[i]) + 1;
            check($sformatf("%s_latency_mc%0d", name, MC[i]), first[i], lat_of(MC[i]));
            check($sformatf("%s_done_cycles_mc%0d", name, MC[i]), hi[i], width);
        end
`ifdef AES_CBC_EN
        model_chain = ct;
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0]   inv_b;
        logic [127:0] want;
        logic [127:0] rkey;
        logic [127:0] rpt;
        int           drop;

        n_vec       = 0;
        n_err       = 0;
        model_chain = '0;
        for (int x = 0; x < 256; x++) begin
            inv_b = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv_b = 8'(y);
            sbox[x] = inv_b ^ rotl8(inv_b, 1) ^ rotl8(inv_b, 2) ^ rotl8(inv_b, 3) ^ rotl8(inv_b, 4) ^ 8'h63;
        end

        rst_n     = 1'b0;
        start     = 1'b0;
        key_valid = 1'b0;
        key_sched = '0;
        msg_enc   = '0;
`ifdef AES_CBC_EN
        iv        = '0;
        iv_load   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_busy_mc%0d", MC[i]), busy[i], 1'b0);
            check($sformatf("rst_done_mc%0d", MC[i]), done[i], 1'b0);
            check($sformatf("rst_dec_mc%0d", MC[i]), dec[i], '0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 C.1 across all three widths, START held through DONE.
        run_op(K_C1, CT_C1, PT_C1 ^ model_chain, -1, "c1_hold");

        // START dropped early: one-cycle DONE, then output holds through idle.
        want = PT_C1 ^ model_chain;
        run_op(K_C1, CT_C1, want, 10, "c1_drop");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("idle_hold_dec_mc%0d", MC[i]), dec[i], want);
                check($sformatf("idle_hold_done_mc%0d", MC[i]), done[i], 1'b0);
            end
        end

        // Key-valid gating: START without KEY_VALID is never accepted.
        key_sched = expand_key(K_C1);
        msg_enc   = CT_C1;
        key_valid = 1'b0;
        start     = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("gate_busy", {busy[0], busy[1], busy[2]}, 3'b000);
        end
        run_op(K_C1, CT_C1, PT_C1 ^ model_chain, -1, "gate");

        // Asynchronous reset in the middle of an operation.
        key_sched = expand_key(K_C1);
        msg_enc   = CT_C1;
        key_valid = 1'b1;
        start     = 1'b1;
        repeat (21) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("arst_busy_mc%0d", MC[i]), busy[i], 1'b0);
            check($sformatf("arst_done_mc%0d", MC[i]), done[i], 1'b0);
            check($sformatf("arst_dec_mc%0d", MC[i]), dec[i], '0);
        end
        start       = 1'b0;
        model_chain = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_no_done", {done[0], done[1], done[2]}, 3'b000);
        run_op(K_C1, CT_C1, PT_C1 ^ model_chain, -1, "arst_c1");

        // Random keys/plaintexts encrypted by the model, decrypted by the DUTs.
        for (int n = 0; n < 6; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            rpt  = {$urandom, $urandom, $urandom, $urandom};
            drop = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 45));
            run_op(rkey, encrypt(expand_key(rkey), rpt), rpt ^ model_chain, drop,
                   $sformatf("rnd%0d", n));
        end

`ifdef AES_CBC_EN
        // SP800-38A CBC two-block chain.
        iv      = IV_CBC;
        iv_load = 1'b1;
        @(negedge clk);
        iv_load     = 1'b0;
        model_chain = IV_CBC;
        run_op(K_CBC, CT_B1, PT_B1, -1, "cbc_b1");
        run_op(K_CBC, CT_B2, PT_B2, -1, "cbc_b2");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
